// File: rtl/mdu_if.sv
// mdu_if: request/result bundle between the EX stage and the multiply/divide unit.
//
// Handshake: `start` is a single-cycle request qualified by `op`, `a`, `b`.
// `busy` low acts as the ready signal: a request is accepted only on an edge
// where `busy` is low. Requests made while `busy` is high are dropped, and the
// issuing side is expected to hold off instead. `hi`/`lo` always show the
// architectural HI/LO registers.
interface mdu_if;
    logic        start;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (output start, op, a, b, input busy, hi, lo);
    modport slave  (input start, op, a, b, output busy, hi, lo);
endinterface

// File: rtl/mdu.sv
// mdu: multi-cycle multiply/divide unit that owns the HI/LO registers.
// Multiply and divide ops hold `busy` for a fixed latency, then commit HI/LO
// in one step. MTHI/MTLO write in a single cycle without raising `busy`.
// Optional feature macro: MDU_MADD_EN enables MADD/MADDU/MSUB/MSUBU (ops 7-10).
// Without the macro, those ops decode as NOP.
module mdu #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic clk,
    input  logic reset,
    mdu_if.slave bus,
    output logic dbg_state
);
    typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_e;

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
    localparam logic [3:0] OP_MADD  = 4'd7;
    localparam logic [3:0] OP_MADDU = 4'd8;
    localparam logic [3:0] OP_MSUB  = 4'd9;
    localparam logic [3:0] OP_MSUBU = 4'd10;

    localparam int              CNT_W     = 16;
    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);

    state_e             state_q, state_d;
    logic [3:0]         op_q, op_d;
    logic [31:0]        a_q, a_d;
    logic [31:0]        b_q, b_d;
    logic [31:0]        hi_q, hi_d;
    logic [31:0]        lo_q, lo_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               is_mul_op;
    logic               is_div_op;

    logic [63:0]        prod_s, prod_u, acc;
    logic [31:0]        a_mag, b_mag, q_mag, r_mag, q_s, r_s, q_u, r_u;

    // Classify the incoming op: multiply-class ops use MULT_CYCLES, divides use DIV_CYCLES.
    always_comb begin
        is_mul_op = (bus.op == OP_MULT) || (bus.op == OP_MULTU);
`ifdef MDU_MADD_EN
        is_mul_op = is_mul_op || ((bus.op >= OP_MADD) && (bus.op <= OP_MSUBU));
`endif
        is_div_op = (bus.op == OP_DIV) || (bus.op == OP_DIVU);
    end

    // Arithmetic on the latched operands. It is only consumed on the commit cycle.
    // Signed divide is done on magnitudes so that 0x80000000 / -1 wraps cleanly.
    always_comb begin
        prod_s = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
        prod_u = {32'd0, a_q} * {32'd0, b_q};
        acc    = {hi_q, lo_q};
        a_mag  = a_q[31] ? (~a_q + 32'd1) : a_q;
        b_mag  = b_q[31] ? (~b_q + 32'd1) : b_q;
        q_mag  = 32'd0;
        r_mag  = 32'd0;
        q_u    = 32'd0;
        r_u    = 32'd0;
        if (b_q != 32'd0) begin
            q_mag = a_mag / b_mag;
            r_mag = a_mag % b_mag;
            q_u   = a_q / b_q;
            r_u   = a_q % b_q;
        end
        q_s = (a_q[31] ^ b_q[31]) ? (~q_mag + 32'd1) : q_mag;
        r_s = a_q[31] ? (~r_mag + 32'd1) : r_mag;
    end

    // Next-state logic: accept in IDLE, count down in RUN, commit HI/LO on the last cycle.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    if (is_mul_op || is_div_op) begin
                        op_d    = bus.op;
                        a_d     = bus.a;
                        b_d     = bus.b;
                        cnt_d   = is_div_op ? DIV_LOAD : MULT_LOAD;
                        state_d = ST_RUN;
                    end else if (bus.op == OP_MTHI) begin
                        hi_d = bus.a;
                    end else if (bus.op == OP_MTLO) begin
                        lo_d = bus.a;
                    end
                end
            end
            ST_RUN: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q <= 1) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                    case (op_q)
                        OP_MULT:  {hi_d, lo_d} = prod_s;
                        OP_MULTU: {hi_d, lo_d} = prod_u;
                        OP_DIV: begin
                            if (b_q != 32'd0) begin
                                lo_d = q_s;
                                hi_d = r_s;
                            end
                        end
                        OP_DIVU: begin
                            if (b_q != 32'd0) begin
                                lo_d = q_u;
                                hi_d = r_u;
                            end
                        end
`ifdef MDU_MADD_EN
                        OP_MADD:  {hi_d, lo_d} = acc + prod_s;
                        OP_MADDU: {hi_d, lo_d} = acc + prod_u;
                        OP_MSUB:  {hi_d, lo_d} = acc - prod_s;
                        OP_MSUBU: {hi_d, lo_d} = acc - prod_u;
`endif
                        default: ;
                    endcase
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and architectural registers. An asynchronous reset drops any in-flight result.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            op_q    <= 4'd0;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.busy  = (state_q == ST_RUN);
    assign bus.hi    = hi_q;
    assign bus.lo    = lo_q;
    assign dbg_state = (state_q == ST_RUN);
endmodule

// File: tb/tb_mdu.sv
// tb_mdu: randomized scoreboard bench for mdu. Directed cases come first,
// followed by a random op mix.
module tb_mdu;
    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic dbg_state;

    mdu_if bus();

    mdu #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
        .clk       (clk),
        .reset     (rst_n),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // Clock
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_mis = 0;
    logic [95:0] exp_q[$];          // {busy length, hi, lo}
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;
    int run_len = 0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: applies one op to the architectural HI/LO and returns the busy length.
    function automatic int model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] acc, ps, pu;
        int sa, sb;
        acc = {m_hi, m_lo};
        ps  = longint'($signed(a)) * longint'($signed(b));
        pu  = {32'd0, a} * {32'd0, b};
        sa  = $signed(a);
        sb  = $signed(b);
        case (op)
            4'd1: begin {m_hi, m_lo} = ps; return MULT_N; end
            4'd2: begin {m_hi, m_lo} = pu; return MULT_N; end
            4'd3: begin
                if (b != 32'd0) begin
                    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                        m_lo = 32'h8000_0000;
                        m_hi = 32'd0;
                    end else begin
                        m_lo = sa / sb;
                        m_hi = sa % sb;
                    end
                end
                return DIV_N;
            end
            4'd4: begin
                if (b != 32'd0) begin
                    m_lo = a / b;
                    m_hi = a % b;
                end
                return DIV_N;
            end
            4'd5: begin m_hi = a; return 0; end
            4'd6: begin m_lo = a; return 0; end
`ifdef MDU_MADD_EN
            4'd7:  begin {m_hi, m_lo} = acc + ps; return MULT_N; end
            4'd8:  begin {m_hi, m_lo} = acc + pu; return MULT_N; end
            4'd9:  begin {m_hi, m_lo} = acc - ps; return MULT_N; end
            4'd10: begin {m_hi, m_lo} = acc - pu; return MULT_N; end
`endif
            default: return 0;
        endcase
    endfunction

    task automatic pop_and_check(input int len);
        logic [95:0] e;
        if (exp_q.size() == 0) begin
            n_vec++;
            n_mis++;
            $display("FAIL unexpected_result: got hi %h lo %h len %0d, expected nothing pending",
                     bus.hi, bus.lo, len);
        end else begin
            e = exp_q.pop_front();
            check32("busy_len", 32'(len), e[95:64]);
            check32("hi", bus.hi, e[63:32]);
            check32("lo", bus.lo, e[31:0]);
        end
    endtask

    // Monitor: compares the result when busy falls, or one cycle after an accepted single-cycle op.
    always begin
        logic s_start, s_busy;
        @(posedge clk);
        s_start = bus.start;
        s_busy  = bus.busy;
        #1;
        if (!rst_n) begin
            run_len = 0;
        end else begin
            if (bus.busy) run_len++;
            if (s_busy && !bus.busy) begin
                pop_and_check(run_len);
                run_len = 0;
            end else if (s_start && !s_busy && !bus.busy) begin
                pop_and_check(0);
            end
        end
    end

    // Driver helpers (called at a negedge; they return at a negedge with busy low)
    task automatic wait_idle();
        int k;
        k = 0;
        while (bus.busy && k < 100) begin
            @(negedge clk);
            k++;
        end
        check32("idle_timeout", 32'(bus.busy), 32'd0);
    endtask

    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        int len;
        len = model(op, a, b);
        exp_q.push_back({32'(len), m_hi, m_lo});
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        @(negedge clk);
        bus.start = 1'b0;
        wait_idle();
    endtask

    task automatic chk_regs(input string name, input logic [31:0] h, input logic [31:0] l);
        check32({name, "_hi"}, bus.hi, h);
        check32({name, "_lo"}, bus.lo, l);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int len;
        logic [3:0]  rop;
        logic [31:0] ra, rb;
        int sel;

        bus.start = 1'b0;
        bus.op    = 4'd0;
        bus.a     = 32'd0;
        bus.b     = 32'd0;
        rst_n     = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check32("reset_busy", 32'(bus.busy), 32'd0);
        chk_regs("reset", 32'd0, 32'd0);

        // Directed cases from the test plan (back-to-back issue).
        issue(4'd1, 32'hFFFF_FFFE, 32'd3);
        chk_regs("mult", 32'hFFFF_FFFF, 32'hFFFF_FFFA);
        issue(4'd2, 32'hFFFF_FFFE, 32'd3);
        chk_regs("multu", 32'h0000_0002, 32'hFFFF_FFFA);
        issue(4'd3, 32'hFFFF_FFF9, 32'd2);
        chk_regs("div", 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        issue(4'd4, 32'd7, 32'd2);
        chk_regs("divu", 32'd1, 32'd3);
        issue(4'd5, 32'h1234_5678, 32'd0);
        issue(4'd3, 32'd5, 32'd0);
        chk_regs("div_by_zero", 32'h1234_5678, 32'd3);
        issue(4'd3, 32'h8000_0000, 32'hFFFF_FFFF);
        chk_regs("div_ovf", 32'd0, 32'h8000_0000);

        // A start issued during RUN must be ignored.
        len = model(4'd1, 32'd7, 32'hFFFF_FFFD);
        exp_q.push_back({32'(len), m_hi, m_lo});
        bus.start = 1'b1; bus.op = 4'd1; bus.a = 32'd7; bus.b = 32'hFFFF_FFFD;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        bus.start = 1'b1; bus.op = 4'd3; bus.a = 32'd100; bus.b = 32'd7;
        @(negedge clk);
        bus.start = 1'b0;
        wait_idle();
        chk_regs("ignore", 32'hFFFF_FFFF, 32'hFFFF_FFEB);

        // Asynchronous reset in the middle of a DIV.
        bus.start = 1'b1; bus.op = 4'd3; bus.a = 32'd1000; bus.b = 32'd3;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check32("abort_busy", 32'(bus.busy), 32'd0);
        chk_regs("abort", 32'd0, 32'd0);
        m_hi = 32'd0;
        m_lo = 32'd0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        issue(4'd2, 32'h0001_0000, 32'h0001_0000);
        chk_regs("after_reset", 32'd1, 32'd0);

`ifdef MDU_MADD_EN
        issue(4'd5, 32'd0, 32'd0);
        issue(4'd6, 32'd10, 32'd0);
        issue(4'd7, 32'd3, 32'd4);
        chk_regs("madd", 32'd0, 32'd22);
        issue(4'd10, 32'd1, 32'd23);
        chk_regs("msubu", 32'hFFFF_FFFF, 32'hFFFF_FFFF);
`else
        issue(4'd5, 32'hCAFE_0001, 32'd0);
        issue(4'd7, 32'd3, 32'd4);
        chk_regs("op7_nop", 32'hCAFE_0001, 32'd0);
`endif

        // Random op mix, including divide-by-zero and signed-overflow corners.
        for (int i = 0; i < 40; i++) begin
            rop = 4'($urandom_range(0, 15));
            ra  = $urandom;
            rb  = $urandom;
            sel = $urandom_range(0, 7);
            if (sel == 0) rb = 32'd0;
            else if (sel == 1) begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
            else if (sel == 2) rb = 32'($urandom_range(1, 9));
            else if (sel == 3) rb = -32'($urandom_range(1, 9));
            issue(rop, ra, rb);
        end

        repeat (3) @(negedge clk);
        check32("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end
endmodule

// File: doc/mdu.md
# mdu

Multiply/divide unit for the P6 pipeline's EX stage: accepts MULT/MULTU/DIV/DIVU and MTHI/MTLO from the decoded instruction, holds the HI/LO architectural registers, and raises `busy` for a fixed multi-cycle latency so the hazard unit can stall MFHI/MFLO and further MDU instructions. Results are committed to HI/LO atomically at the end of the busy window. The testbench's `clk`/`reset` reach this block unchanged through the `mips` top.

## Interface
- `MULT_CYCLES`, 5: busy duration for multiply ops, ≥1.
- `DIV_CYCLES`, 10: busy duration for divide ops, ≥1.
- `clk`  in  1  single system clock, rising-edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle request; `op`, `a`, `b` valid when high.
- `op`  in  4  0 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 MADD, 8 MADDU, 9 MSUB, 10 MSUBU (7–10 need `MDU_MADD_EN`); others = NOP.
- `a`  in  32  rs operand.
- `b`  in  32  rt operand.
- `busy`  out  1  high while an operation is in flight.
- `hi`  out  32  HI register.
- `lo`  out  32  LO register.

## Operation
- States: IDLE, RUN. Reset → IDLE, `busy`=0, `hi`=0, `lo`=0, counter=0.
- IDLE + `start` + mult/div op (1–4, 7–10): latch operands and op, load counter with MULT_CYCLES or DIV_CYCLES, go RUN.
- RUN: counter decrements each cycle; at counter==1, write HI/LO and go IDLE.
- MTHI/MTLO with `start` in IDLE: `hi` (or `lo`) ← `a` at that edge; no RUN, `busy` stays 0.
- `start` while RUN: ignored entirely (hazard unit guarantees no issue while `busy`; bench checks ignore).
- `start` with op NOP/undefined: no effect.
- MULT: {hi,lo} ← signed(a)×signed(b), 64-bit. MULTU: unsigned.
- DIV: lo ← a/b signed, truncated toward zero; hi ← remainder, sign of dividend. DIVU: unsigned.
- b==0 on DIV/DIVU: full busy window runs, HI/LO unchanged.
- DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
- HI/LO hold old values throughout RUN; no partial updates.
- `reset` asserted mid-RUN: immediate abort, all outputs to reset values, result discarded.

## Timing
- Edge E samples `start`; `busy` high from E+ through the edge E+N (N = configured cycles), i.e. exactly N cycles high.
- HI/LO new values visible in the same cycle `busy` falls.
- Back-to-back: new `start` accepted in the first cycle `busy` is low.
- MTHI/MTLO: `hi`/`lo` visible the cycle after `start`.
- Hazard contract: ID stalls MF*/MT*/MDU ops when `busy` or (`start` and EX op is mult/div).

## Configuration
- `MDU_MADD_EN` defined: ops 7–10 implemented; {hi,lo} ← {hi,lo} ± product (signed for MADD/MSUB, unsigned for MADDU/MSUBU), mod 2^64, using MULT_CYCLES latency; accumulation uses HI/LO values at commit time.
- Undefined: ops 7–10 decode as NOP (no busy, no HI/LO change).

## Test plan
- Reset release, then MULT a=0xFFFFFFFE (−2), b=3 → busy high exactly 5 cycles; hi=0xFFFFFFFF, lo=0xFFFFFFFA; MULTU same operands → hi=0x00000002, lo=0xFFFFFFFA.
- DIV a=0xFFFFFFF9 (−7), b=2 → busy 10 cycles; lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU a=7, b=2 → lo=3, hi=1.
- MTHI a=0x12345678 then DIV a=5, b=0 → hi stays 0x12345678, lo unchanged, busy still 10 cycles; DIV 0x80000000/0xFFFFFFFF → lo=0x80000000, hi=0.
- MULT started, `start`+DIV issued at cycle 2 of RUN → ignored; final HI/LO = MULT result, busy falls at cycle 5.
- Assert `reset` low at cycle 3 of a DIV → busy, hi, lo go 0 without waiting for clk edge; next op after release behaves normally.
- With `MDU_MADD_EN`: hi=0, lo=10, MADD a=3, b=4 → lo=22 after 5 cycles; MSUBU a=1, b=23 → {hi,lo}=0xFFFFFFFF_FFFFFFFF. Without macro: op 7 → no busy, HI/LO unchanged.
